regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (RegWrite/RD/WriteData, written on negedge clk) between two writeback requesters: the ALU pipeline and the load/memory return path. Each requester gets a small FIFO with valid/ready handshake. A fixed-priority arbiter with an anti-starvation counter drains the FIFOs. A pending-write scoreboard is exported so hazard logic can stall readers of registers with queued writes.

Parameters:
XLEN, 64, data width of register-file entries
DEPTH, 2, entries per requester FIFO (power of two, >=2)
STARVE_LIMIT, 3, max consecutive ALU grants while MEM waits

Ports:
clk  input  1  system clock, rising-edge logic
reset  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU FIFO can accept
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
mem_valid  input  1  memory writeback request
mem_ready  output  1  MEM FIFO can accept
mem_rd  input  5  memory destination register
mem_data  input  XLEN  load data
RegWrite  output  1  register-file write enable (registered)
RD  output  5  register-file write address (registered)
WriteData  output  XLEN  register-file write data (registered)
pending  output  32  bit r set while a write to xr is queued or in flight

Behaviour:
- Reset (reset=0, async): FIFOs emptied; RegWrite=0, RD=0, WriteData=0; starvation counter=0; alu_ready=mem_ready=0; pending=0. After release, readys go to 1 on the first clk edge or combinationally from the empty state. Either is acceptable, but RTL must document which.
- Reset mid-operation: all queued and in-flight writes are discarded. RegWrite drops immediately and no write occurs.
- Handshake: transfer occurs on a rising edge with valid&&ready. ready = !fifo_full and depends on no *_valid input. A full FIFO never accepts, including in the same cycle as a pop; ready rises the cycle after the pop.
- Writes to x0: accepted as normal (ready rules apply), then dropped. Not enqueued, no pending bit, no RegWrite.
- Ordering: FIFO order within a requester. No ordering guarantee across requesters. Upstream uses pending to avoid two in-flight writes to the same rd from different requesters.
- Arbitration: evaluated every cycle on the FIFO heads.
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: MEM is granted if starve_cnt==STARVE_LIMIT, otherwise ALU.
  - starve_cnt increments on an ALU grant while MEM is non-empty (saturates at STARVE_LIMIT).
  - starve_cnt clears on a MEM grant or whenever MEM is empty.
- Grant: pops the head. At the next rising edge, RegWrite=1 and RD/WriteData take the head's rd/data.
  - The register file captures the write on the following falling edge.
  - With no grant, RegWrite=0 and RD/WriteData hold their last values.
- Latency: an entry accepted at edge N into an empty FIFO with no contention drives RegWrite at edge N+1. Throughput is one write per cycle.
- pending: bit r=1 if any valid entry in either FIFO has rd==r, OR (RegWrite==1 and RD==r). Combinational from state; pending[0]=0 always.
  - A bit sets the cycle after acceptance.
  - A bit clears after the cycle in which RegWrite drove it, unless another queued entry targets the same rd.
- Widths: starvation counter width is $clog2(STARVE_LIMIT+1). FIFO pointers carry an extra wrap bit; full/empty come from pointer compare.

Decomposition:
- Shared package regfile_pkg:
  - XLEN, REG_ADDR_W=5, NUM_REGS=32
  - wb_entry_t struct {rd[4:0], data[XLEN-1:0]}
- One sub-module, regwb_fifo: parameterised DEPTH, synchronous FIFO of wb_entry_t with async active-low reset. Outputs full/empty, head entry, and per-entry valid+rd for the pending decode. Instantiated twice.

Test Plan:
- Reset release, ALU only: alu rd=5 data=0x1234 accepted at edge N -> RegWrite=1, RD=5, WriteData=0x1234 at edge N+1. pending[5]=1 from N through N+1's cycle, then 0.
- Simultaneous: alu rd=1 data=0xA and mem rd=2 data=0xB accepted in the same cycle -> write x1=0xA one cycle, x2=0xB the next. pending[1] and pending[2] both set while queued.
- Starvation: ALU valid every cycle (rd=3..), one MEM entry rd=7 -> exactly 3 ALU grants, then the MEM grant RD=7, then ALU resumes. starve_cnt returns to 0.
- x0 drop: alu rd=0 data=0xFFFF accepted -> RegWrite stays 0, pending unchanged, alu_ready stays 1.
- Backpressure: ALU saturating, MEM presents 3 entries -> mem_ready low after 2 queued. The third entry is accepted only after the first MEM grant. No entry lost or duplicated; read back through the register file.
- Async reset mid-flight: 2 entries queued plus RegWrite=1 -> reset=0 between edges drops RegWrite, RD, WriteData and pending to 0 immediately. After release, no further writes and the register file is unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
// wb_entry_t is one queued write: destination register plus data.
package regfile_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// Small synchronous FIFO of writeback entries. It exposes per-slot
// valid/rd so the parent can decode which registers have queued writes.
module regwb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              push,
   input  wb_entry_t                         push_entry,
   input  logic                              pop,
   output logic                              full,
   output logic                              empty,
   output wb_entry_t                         head,
   output logic [DEPTH-1:0]                  ent_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]  ent_rd
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   count;
   logic [AW-1:0] offset;
   wb_entry_t     slots [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) slots[wr_ptr[AW-1:0]] <= push_entry;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = slots[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;

   // A slot is live when its distance from the read pointer is below the fill level.
   always_comb begin
      offset    = '0;
      ent_valid = '0;
      ent_rd    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset       = AW'(i) - rd_ptr[AW-1:0];
         ent_valid[i] = ({1'b0, offset} < count);
         ent_rd[i]    = slots[i].rd;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU and memory writeback
// paths: two FIFOs, fixed ALU priority with MEM anti-starvation, pending scoreboard.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int XLEN         = regfile_pkg::XLEN,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] RD,
   output logic [XLEN-1:0]       WriteData,
   output logic [NUM_REGS-1:0]   pending
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   wb_entry_t                       alu_in, mem_in, alu_head, mem_head;
   logic                            alu_full, alu_empty, mem_full, mem_empty;
   logic                            alu_push, mem_push;
   logic                            grant_alu, grant_mem;
   logic [DEPTH-1:0]                alu_ent_valid, mem_ent_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] alu_ent_rd, mem_ent_rd;
   logic [SW-1:0]                   starve_cnt;

   // Readys are gated by reset itself, so they rise combinationally the moment
   // reset releases (FIFOs are empty then), without waiting for a clock edge.
   assign alu_ready = reset & ~alu_full;
   assign mem_ready = reset & ~mem_full;

   // Writes to x0 complete the handshake but are never queued.
   assign alu_push = alu_valid & alu_ready & (alu_rd != '0);
   assign mem_push = mem_valid & mem_ready & (mem_rd != '0);
   assign alu_in   = '{rd: alu_rd, data: alu_data};
   assign mem_in   = '{rd: mem_rd, data: mem_data};

   regwb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (alu_push),
      .push_entry (alu_in),
      .pop        (grant_alu),
      .full       (alu_full),
      .empty      (alu_empty),
      .head       (alu_head),
      .ent_valid  (alu_ent_valid),
      .ent_rd     (alu_ent_rd)
   );

   regwb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (mem_push),
      .push_entry (mem_in),
      .pop        (grant_mem),
      .full       (mem_full),
      .empty      (mem_empty),
      .head       (mem_head),
      .ent_valid  (mem_ent_valid),
      .ent_rd     (mem_ent_rd)
   );

   // ALU wins contention until MEM has been passed over STARVE_LIMIT times in a row.
   always_comb begin
      grant_mem = ~mem_empty & (alu_empty | (starve_cnt == STARVE_MAX));
      grant_alu = ~alu_empty & ~grant_mem;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (mem_empty || grant_mem) begin
         starve_cnt <= '0;
      end else if (grant_alu && starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Write port register; the register file samples it on the following falling edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWrite  <= 1'b0;
         RD        <= '0;
         WriteData <= '0;
      end else begin
         RegWrite <= grant_alu | grant_mem;
         if (grant_alu) begin
            RD        <= alu_head.rd;
            WriteData <= XLEN'(alu_head.data);
         end else if (grant_mem) begin
            RD        <= mem_head.rd;
            WriteData <= XLEN'(mem_head.data);
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_ent_valid[i]) pending[alu_ent_rd[i]] = 1'b1;
         if (mem_ent_valid[i]) pending[mem_ent_rd[i]] = 1'b1;
      end
      if (RegWrite) pending[RD] = 1'b1;
      pending[0] = 1'b0;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// checked against a queue-based model of the writeback rules.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIM   = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, mem_valid;
   logic        alu_ready, mem_ready;
   logic [4:0]  alu_rd, mem_rd;
   logic [63:0] alu_data, mem_data;
   logic        RegWrite;
   logic [4:0]  RD;
   logic [63:0] WriteData;
   logic [31:0] pending;

   regfile_wb_arbiter #(.XLEN(64), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .RegWrite  (RegWrite),
      .RD        (RD),
      .WriteData (WriteData),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // Register file driven by the DUT write port, written on the falling edge.
   logic [63:0] rf_d [32];
   always @(negedge clk) if (RegWrite) rf_d[RD] = WriteData;

   // Reference model state
   wb_entry_t   aq[$];
   wb_entry_t   mq[$];
   int          starve;
   bit          m_rw;
   logic [4:0]  m_rd;
   logic [63:0] m_wd;
   logic [63:0] rf_m [32];
   bit          last_acc_a, last_acc_m;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_pending();
      logic [31:0] p = '0;
      foreach (aq[i]) p[aq[i].rd] = 1'b1;
      foreach (mq[i]) p[mq[i].rd] = 1'b1;
      if (m_rw) p[m_rd] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic model_reset();
      aq.delete();
      mq.delete();
      starve = 0;
      m_rw   = 1'b0;
      m_rd   = '0;
      m_wd   = '0;
   endtask

   // One clock: predict from the pre-edge state, advance the edge, compare.
   task automatic step();
      bit a_v, m_v, acc_a, acc_m, ga, gm, mem_ne;
      logic [4:0]  a_rd, mm_rd;
      logic [63:0] a_d, mm_d;
      wb_entry_t   e;
      if (m_rw) rf_m[m_rd] = m_wd;
      a_v = alu_valid; m_v = mem_valid;
      a_rd = alu_rd; mm_rd = mem_rd; a_d = alu_data; mm_d = mem_data;
      acc_a  = a_v && (aq.size() < DEPTH);
      acc_m  = m_v && (mq.size() < DEPTH);
      mem_ne = (mq.size() > 0);
      if (aq.size() > 0 && mem_ne) gm = (starve == LIM);
      else                         gm = mem_ne;
      ga = (aq.size() > 0) && !gm;
      @(posedge clk);
      #1;
      if (ga) begin
         e = aq.pop_front();
         m_rw = 1'b1; m_rd = e.rd; m_wd = e.data;
      end else if (gm) begin
         e = mq.pop_front();
         m_rw = 1'b1; m_rd = e.rd; m_wd = e.data;
      end else begin
         m_rw = 1'b0;
      end
      if (gm || !mem_ne) starve = 0;
      else if (ga && starve < LIM) starve++;
      if (acc_a && a_rd != 0) aq.push_back(wb_entry_t'{rd: a_rd, data: a_d});
      if (acc_m && mm_rd != 0) mq.push_back(wb_entry_t'{rd: mm_rd, data: mm_d});
      last_acc_a = acc_a;
      last_acc_m = acc_m;
      chk("regwrite",  RegWrite,  m_rw);
      chk("rd",        RD,        m_rd);
      chk("writedata", WriteData, m_wd);
      chk("alu_ready", alu_ready, aq.size() < DEPTH);
      chk("mem_ready", mem_ready, mq.size() < DEPTH);
      chk("pending",   pending,   model_pending());
   endtask

   task automatic drain();
      int n = 0;
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      while ((aq.size() > 0 || mq.size() > 0 || m_rw) && n < 20) begin
         step();
         n++;
      end
      chk("drain_done", (aq.size() == 0 && mq.size() == 0 && !m_rw), 1'b1);
   endtask

   task automatic compare_rf(input string tag);
      for (int r = 0; r < 32; r++) chk(tag, rf_d[r], rf_m[r]);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rw"},    RegWrite,  1'b0);
      chk({tag, "_rd"},    RD,        5'd0);
      chk({tag, "_wd"},    WriteData, 64'd0);
      chk({tag, "_pend"},  pending,   32'd0);
      chk({tag, "_ardy"},  alu_ready, 1'b0);
      chk({tag, "_mrdy"},  mem_ready, 1'b0);
   endtask

   initial begin
      int arn, idx;
      logic [4:0]  mrds [3];
      logic [63:0] snap10;

      reset = 1'b0;
      alu_valid = 1'b0; mem_valid = 1'b0;
      alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
      for (int r = 0; r < 32; r++) begin rf_d[r] = '0; rf_m[r] = '0; end
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      #2 reset = 1'b1;
      #1;
      chk("rel_alu_ready", alu_ready, 1'b1);
      chk("rel_mem_ready", mem_ready, 1'b1);

      // Single ALU write with one-cycle latency
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
      step();
      alu_valid = 1'b0;
      chk("t1_pend_q",  pending[5], 1'b1);
      chk("t1_rw_idle", RegWrite,   1'b0);
      step();
      chk("t1_rw", RegWrite,   1'b1);
      chk("t1_rd", RD,         5'd5);
      chk("t1_wd", WriteData,  64'h1234);
      chk("t1_pend_f", pending[5], 1'b1);
      step();
      chk("t1_pend_clr", pending[5], 1'b0);

      // Simultaneous ALU and MEM requests
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA;
      mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'hB;
      step();
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("t2_pend1", pending[1], 1'b1);
      chk("t2_pend2", pending[2], 1'b1);
      step();
      chk("t2_first_rd", RD, 5'd1);
      chk("t2_first_wd", WriteData, 64'hA);
      step();
      chk("t2_second_rd", RD, 5'd2);
      chk("t2_second_wd", WriteData, 64'hB);
      drain();

      // Starvation: ALU streams, one MEM entry waits three ALU grants
      arn = 3;
      alu_valid = 1'b1; alu_rd = 5'(arn); alu_data = 64'h300;
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h700;
      for (int s = 1; s <= 7; s++) begin
         step();
         if (last_acc_m) mem_valid = 1'b0;
         if (last_acc_a) begin
            arn++;
            alu_rd = 5'(arn);
            alu_data = 64'h300 + 64'(arn);
         end
         if (s >= 2 && s <= 4) chk("t3_alu_grant", RD, 5'(s + 1));
         if (s == 5) chk("t3_mem_grant", RD, 5'd7);
         if (s == 6) chk("t3_alu_resume", (RegWrite && RD != 5'd7), 1'b1);
      end
      drain();

      // x0 write is accepted and dropped
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
      step();
      alu_valid = 1'b0;
      chk("t4_acc",  last_acc_a, 1'b1);
      chk("t4_pend", pending,    32'd0);
      chk("t4_rdy",  alu_ready,  1'b1);
      step();
      chk("t4_rw",   RegWrite,   1'b0);

      // Backpressure: ALU saturating while MEM offers three entries
      mrds[0] = 5'd20; mrds[1] = 5'd21; mrds[2] = 5'd22;
      idx = 0;
      alu_valid = 1'b1;
      mem_valid = 1'b1; mem_rd = mrds[0]; mem_data = 64'hD000;
      for (int s = 0; s < 16; s++) begin
         alu_rd   = 5'($urandom_range(8, 15));
         alu_data = {$urandom, $urandom};
         step();
         if (last_acc_m) begin
            idx++;
            if (idx == 2) chk("t5_mem_full", mem_ready, 1'b0);
            if (idx < 3) begin
               mem_rd = mrds[idx]; mem_data = 64'hD000 + 64'(idx);
            end else begin
               mem_valid = 1'b0;
            end
         end
      end
      chk("t5_all_mem_accepted", idx, 3);
      drain();
      compare_rf("t5_rf");

      // Random traffic
      for (int s = 0; s < 400; s++) begin
         alu_valid = 1'($urandom_range(0, 1));
         mem_valid = 1'($urandom_range(0, 1));
         alu_rd    = 5'($urandom_range(0, 31));
         mem_rd    = 5'($urandom_range(0, 31));
         alu_data  = {$urandom, $urandom};
         mem_data  = {$urandom, $urandom};
         step();
      end
      drain();
      compare_rf("rand_rf");

      // Asynchronous reset with writes queued and in flight
      snap10 = rf_d[10];
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hAAAA;
      mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 64'hCCCC;
      step();
      alu_rd = 5'd11; alu_data = 64'hBBBB;
      mem_rd = 5'd13; mem_data = 64'hDDDD;
      step();
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("t6_inflight", RegWrite, 1'b1);
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk_zero("t6_async");
      @(posedge clk);
      #1;
      chk_zero("t6_hold");
      #2 reset = 1'b1;
      for (int s = 0; s < 5; s++) step();
      chk("t6_x10_kept", rf_d[10], snap10);
      compare_rf("t6_rf");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
